rega_sequencer: RTL

Registered FSM that sequences the irrigation datapath. It arbitrates sprinkler (asp), drip (got) and fertilize requests, and fills the tank when the level is insufficient. It times each irrigation run and drives the mandatory flush after drip runs. Its outputs feed the irrigation validator directly (asp/got commands, 2-bit state code, cleaning code, fill valve), and the validator's error flag comes back as erro_in.

---
 rtl/rega_pkg.sv | 42 ++++
 rtl/rega_timer.sv | 29 ++
 rtl/rega_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rega_pkg.sv
// Shared types and encodings for the irrigation sequencer.
package rega_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_CLEAN,
    ST_IRRIGATE,
    ST_FAULT
  } state_e;

  typedef enum logic {
    MODE_ASP,
    MODE_GOT
  } mode_e;

  localparam logic [1:0] MEF_IDLE     = 2'b00;
  localparam logic [1:0] MEF_FILL     = 2'b01;
  localparam logic [1:0] MEF_CLEAN    = 2'b10;
  localparam logic [1:0] MEF_IRRIGATE = 2'b11;
  localparam logic [1:0] MEF_FAULT    = 2'b00;

  localparam logic [1:0] LIMP_NONE  = 2'b00;
  localparam logic [1:0] LIMP_ADUBO = 2'b01;
  localparam logic [1:0] LIMP_FLUSH = 2'b10;

  // FAULT shares code 00 with IDLE; the validator tells them apart via fault.
  function automatic logic [1:0] mef_code(input state_e s);
    logic [1:0] code;
    code = MEF_IDLE;
    case (s)
      ST_IDLE:     code = MEF_IDLE;
      ST_FILL:     code = MEF_FILL;
      ST_CLEAN:    code = MEF_CLEAN;
      ST_IRRIGATE: code = MEF_IRRIGATE;
      ST_FAULT:    code = MEF_FAULT;
      default:     code = MEF_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/rega_timer.sv
// Saturating up-counter with synchronous clear, enable-to-count and a
// terminal flag against a runtime limit.
module rega_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;

  // Count register: clear wins over enable, never wraps past all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/rega_sequencer.sv
// Irrigation sequencer: arbitrates sprinkler/drip/fertilize requests, fills
// the tank when low, times each run and drives the flush after drip runs.
//
// state       | meaning
// ------------+----------------------------------------------------
// ST_IDLE     | waiting; arbitrates pending requests
// ST_FILL     | tank valve open, irrigation timer held
// ST_IRRIGATE | asp or got command active, irrigation timer running
// ST_CLEAN    | flush (after drip) or fertilize phase
// ST_FAULT    | all commands off until clr_fault
module rega_sequencer
  import rega_pkg::*;
#(
  parameter int REGA_CYCLES    = 16,
  parameter int LIMPEZA_CYCLES = 8,
  parameter int FILL_TIMEOUT   = 32,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_asp,
  input  logic       req_got,
  input  logic       req_adubo,
  input  logic       nivel_ok,
  input  logic       nivel_cheio,
  input  logic       stop,
  input  logic       erro_in,
  input  logic       clr_fault,
  output logic       asp,
  output logic       got,
  output logic       ve,
  output logic [1:0] limpeza,
  output logic [1:0] mef,
  output logic       busy,
  output logic       fault
);

  localparam logic [CNT_W-1:0] REGA_LIM  = CNT_W'(REGA_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIMP_LIM  = CNT_W'(LIMPEZA_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILL_LIM  = CNT_W'(FILL_TIMEOUT - 1);

  state_e     state_q, state_d;
  mode_e      mode_q, mode_d;
  logic [1:0] limp_q, limp_d;
  logic       pend_asp_q, pend_asp_d;
  logic       pend_got_q, pend_got_d;
  logic       pend_adubo_q, pend_adubo_d;

  logic       asp_q, got_q, ve_q, busy_q, fault_q;
  logic [1:0] limpeza_q, mef_q;
  logic       asp_d, got_d, ve_d, busy_d, fault_d;
  logic [1:0] limpeza_d, mef_d;

  logic             run_clr, run_en, run_tc;
  logic [CNT_W-1:0] run_lim;
  logic             fill_tc;
  logic             eff_asp, eff_got, eff_adubo;

  // One run timer serves IRRIGATE (held through FILL) and CLEAN.
  assign run_lim = (state_q == ST_CLEAN) ? LIMP_LIM : REGA_LIM;

  rega_timer #(.CNT_W(CNT_W)) u_run_tmr (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (run_clr),
    .en_i    (run_en),
    .limit_i (run_lim),
    .tc_o    (run_tc)
  );

  // Fill timeout counts only while in FILL; it must not disturb the held run time.
  rega_timer #(.CNT_W(CNT_W)) u_fill_tmr (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (state_q != ST_FILL),
    .en_i    (state_q == ST_FILL),
    .limit_i (FILL_LIM),
    .tc_o    (fill_tc)
  );

  // Next-state, pending-flag and registered-output decode.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    limp_d       = limp_q;
    pend_asp_d   = pend_asp_q;
    pend_got_d   = pend_got_q;
    pend_adubo_d = pend_adubo_q;
    run_clr      = 1'b0;
    run_en       = 1'b0;
    eff_asp      = pend_asp_q | req_asp;
    eff_got      = pend_got_q | req_got;
    eff_adubo    = pend_adubo_q | req_adubo;

    case (state_q)
      ST_IDLE: begin
        run_clr = 1'b1;
        if (eff_asp) begin
          mode_d  = MODE_ASP;
          state_d = nivel_ok ? ST_IRRIGATE : ST_FILL;
        end else if (eff_got) begin
          mode_d  = MODE_GOT;
          state_d = nivel_ok ? ST_IRRIGATE : ST_FILL;
        end else if (eff_adubo) begin
          limp_d  = LIMP_ADUBO;
          state_d = ST_CLEAN;
        end
      end
      ST_FILL: begin
        if (erro_in) begin
          state_d = ST_FAULT;
        end else if (stop) begin
          state_d = ST_IDLE;
          run_clr = 1'b1;
          if (mode_q == MODE_ASP) pend_asp_d = 1'b0;
          else                    pend_got_d = 1'b0;
        end else if (nivel_cheio) begin
          state_d = ST_IRRIGATE;
        end else if (fill_tc) begin
          state_d = ST_FAULT;
        end
      end
      ST_IRRIGATE: begin
        if (erro_in) begin
          state_d = ST_FAULT;
        end else if (stop) begin
          state_d = ST_IDLE;
          run_clr = 1'b1;
          if (mode_q == MODE_ASP) pend_asp_d = 1'b0;
          else                    pend_got_d = 1'b0;
        end else if (run_tc) begin
          run_clr = 1'b1;
          if (mode_q == MODE_GOT) begin
            pend_got_d = 1'b0;
            limp_d     = LIMP_FLUSH;
            state_d    = ST_CLEAN;
          end else begin
            pend_asp_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end else begin
          // Counting on the edge that leaves for FILL keeps the total on-time exact.
          run_en = 1'b1;
          if (!nivel_ok) state_d = ST_FILL;
        end
      end
      ST_CLEAN: begin
        if (erro_in) begin
          state_d = ST_FAULT;
        end else if (stop || run_tc) begin
          state_d = ST_IDLE;
          run_clr = 1'b1;
          if (limp_q == LIMP_ADUBO) pend_adubo_d = 1'b0;
        end else begin
          run_en = 1'b1;
        end
      end
      ST_FAULT: begin
        run_clr = 1'b1;
        if (clr_fault) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_FAULT) begin
      pend_asp_d   = 1'b0;
      pend_got_d   = 1'b0;
      pend_adubo_d = 1'b0;
      run_clr      = 1'b1;
    end else if (state_q != ST_FAULT) begin
      pend_asp_d   = pend_asp_d | req_asp;
      pend_got_d   = pend_got_d | req_got;
      pend_adubo_d = pend_adubo_d | req_adubo;
    end

    asp_d     = (state_d == ST_IRRIGATE) && (mode_d == MODE_ASP);
    got_d     = (state_d == ST_IRRIGATE) && (mode_d == MODE_GOT);
    ve_d      = (state_d == ST_FILL);
    limpeza_d = (state_d == ST_CLEAN) ? limp_d : LIMP_NONE;
    mef_d     = mef_code(state_d);
    busy_d    = (state_d != ST_IDLE);
    fault_d   = (state_d == ST_FAULT);
  end

  // State, mode, pending flags and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_ASP;
      limp_q       <= LIMP_NONE;
      pend_asp_q   <= 1'b0;
      pend_got_q   <= 1'b0;
      pend_adubo_q <= 1'b0;
      asp_q        <= 1'b0;
      got_q        <= 1'b0;
      ve_q         <= 1'b0;
      limpeza_q    <= LIMP_NONE;
      mef_q        <= MEF_IDLE;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      limp_q       <= limp_d;
      pend_asp_q   <= pend_asp_d;
      pend_got_q   <= pend_got_d;
      pend_adubo_q <= pend_adubo_d;
      asp_q        <= asp_d;
      got_q        <= got_d;
      ve_q         <= ve_d;
      limpeza_q    <= limpeza_d;
      mef_q        <= mef_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
    end
  end

  assign asp     = asp_q;
  assign got     = got_q;
  assign ve      = ve_q;
  assign limpeza = limpeza_q;
  assign mef     = mef_q;
  assign busy    = busy_q;
  assign fault   = fault_q;

  a_cmd_excl: assert property (@(posedge clk) disable iff (reset)
    $onehot0({asp_q, got_q, ve_q}));

endmodule
